// File: rtl/frame_buffer_scheduler_pkg.sv
// Shared encodings for the frame buffer scheduler: FSM states and arbiter grant identities.
package frame_buffer_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic GNT_RD = 1'b0;
    localparam logic GNT_WR = 1'b1;

endpackage

// File: rtl/frame_ptr_counter.sv
// Frame address pointer: one bit wider than the RAM address so a full frame count is representable.
module frame_ptr_counter #(
    parameter int unsigned W = 17
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Single-port frame RAM scheduler: arbitrates each RAM cycle between the capture writer and the
// processing reader, keeping reads strictly behind writes within one frame.
module frame_buffer_scheduler
    import frame_buffer_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FRAME_PIXELS = 65536
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    input  logic              i_rd_req,
    output logic              o_rd_grant,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy,
    output logic              o_frame_done
);

    localparam logic [ADDR_W:0] FP      = (ADDR_W+1)'(FRAME_PIXELS);
    localparam logic [ADDR_W:0] FP_LAST = FP - (ADDR_W+1)'(1);

    state_e      r_state;
    logic        r_last_grant;
    logic        r_rd_valid;
    logic        r_frame_done;

    logic [ADDR_W:0] w_wr_cnt;
    logic [ADDR_W:0] w_rd_cnt;
    logic            w_active;
    logic            w_frame_start;
    logic            w_weli;
    logic            w_reli;
    logic            w_gnt_wr;
    logic            w_gnt_rd;
    logic            w_rd_last;

    assign w_active      = (r_state == ACTIVE);
    assign w_frame_start = i_start && !w_active;

    // Strict less-than keeps the reader off the pixel being written this same cycle.
    assign w_weli = w_active && i_wr_valid && (w_wr_cnt < FP);
    assign w_reli = w_active && i_rd_req && (w_rd_cnt < w_wr_cnt);

    assign w_gnt_wr  = w_weli && (!w_reli || (r_last_grant == GNT_RD));
    assign w_gnt_rd  = w_reli && (!w_weli || (r_last_grant == GNT_WR));
    assign w_rd_last = (w_rd_cnt == FP_LAST);

    frame_ptr_counter #(
        .W (ADDR_W + 1)
    ) u_wr_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_reset_n),
        .i_clr   (w_frame_start),
        .i_inc   (w_gnt_wr),
        .o_cnt   (w_wr_cnt)
    );

    frame_ptr_counter #(
        .W (ADDR_W + 1)
    ) u_rd_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_reset_n),
        .i_clr   (w_frame_start),
        .i_inc   (w_gnt_rd),
        .o_cnt   (w_rd_cnt)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= GNT_RD;
            r_rd_valid   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_rd_valid   <= w_gnt_rd;
            r_frame_done <= w_gnt_rd && w_rd_last;
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_state      <= ACTIVE;
                        r_last_grant <= GNT_RD;
                    end
                end
                ACTIVE: begin
                    if (w_gnt_wr) begin
                        r_last_grant <= GNT_WR;
                    end else if (w_gnt_rd) begin
                        r_last_grant <= GNT_RD;
                    end
                    if (w_gnt_rd && w_rd_last) begin
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_wr_ready   = w_gnt_wr;
    assign o_rd_grant   = w_gnt_rd;
    assign o_mem_en     = w_gnt_wr || w_gnt_rd;
    assign o_mem_we     = w_gnt_wr;
    assign o_mem_addr   = w_gnt_wr ? w_wr_cnt[ADDR_W-1:0] : w_rd_cnt[ADDR_W-1:0];
    assign o_mem_wdata  = i_wr_data;
    assign o_rd_data    = i_mem_rdata;
    assign o_rd_valid   = r_rd_valid;
    assign o_frame_done = r_frame_done;
    assign o_busy       = w_active;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for frame_buffer_scheduler with a 1-cycle RAM model and a read-data scoreboard.
module tb_frame_buffer_scheduler;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned FRAME_PIXELS = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              wr_valid = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_req = 1'b0;
    logic              wr_ready, rd_grant, rd_valid, mem_en, mem_we, busy, frame_done;
    logic [DATA_W-1:0] rd_data, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    logic [DATA_W-1:0] ram [8];
    logic [DATA_W-1:0] model [8];
    logic [DATA_W-1:0] exp_q [$];
    int n_checks = 0;
    int n_pass = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    frame_buffer_scheduler #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .FRAME_PIXELS (FRAME_PIXELS)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_start      (start),
        .i_wr_valid   (wr_valid),
        .i_wr_data    (wr_data),
        .o_wr_ready   (wr_ready),
        .i_rd_req     (rd_req),
        .o_rd_grant   (rd_grant),
        .o_rd_valid   (rd_valid),
        .o_rd_data    (rd_data),
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard side: every rd_valid must match the oldest expected read.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
            else                   check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        if (frame_done) begin
            n_done = n_done + 1;
            check("done_with_valid", 32'(rd_valid), 32'd1);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        next();
        start = 1'b0;
    endtask

    task automatic expect_wr(input int a);
        check("wr_ready", 32'(wr_ready), 32'd1);
        check("wr_we", 32'(mem_we), 32'd1);
        check("wr_addr", 32'(mem_addr), 32'(a));
        check("wr_no_rd", 32'(rd_grant), 32'd0);
    endtask

    task automatic expect_rd(input int a, input bit push);
        check("rd_grant", 32'(rd_grant), 32'd1);
        check("rd_en", 32'(mem_en), 32'd1);
        check("rd_we", 32'(mem_we), 32'd0);
        check("rd_addr", 32'(mem_addr), 32'(a));
        if (push) exp_q.push_back(model[a]);
    endtask

    task automatic expect_idle_bus();
        check("no_wr", 32'(wr_ready), 32'd0);
        check("no_rd", 32'(rd_grant), 32'd0);
        check("no_en", 32'(mem_en), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        expect_idle_bus();
        next();
        reset_n = 1'b1;
        next();

        // T1 write only, then T6 address coverage on the write side
        do_start();
        wr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_data = 8'(8'h30 + i);
            @(negedge clk);
            if (i < 8) begin
                expect_wr(i);
                model[i] = wr_data;
            end else begin
                expect_idle_bus();
            end
            check("t1_busy", 32'(busy), 32'd1);
            next();
        end

        // T4a start mid-frame is ignored: write pointer stays saturated
        start = 1'b1;
        @(negedge clk);
        check("t4_busy", 32'(busy), 32'd1);
        next();
        start = 1'b0;
        @(negedge clk);
        check("t4_no_clear", 32'(wr_ready), 32'd0);
        next();

        // Read side of the full frame: addr 7 once, no 9th grant
        wr_valid = 1'b0;
        rd_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 8) begin
                expect_rd(i, 1'b1);
            end else begin
                expect_idle_bus();
                check("t6_busy", 32'(busy), 32'd0);
                check("t6_done", 32'(frame_done), (i == 8) ? 32'd1 : 32'd0);
            end
            next();
        end
        check("t6_done_count", 32'(n_done), 32'd1);

        // T2 read gating from DONE restart
        do_start();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_gated", 32'(rd_grant), 32'd0);
            check("t2_busy", 32'(busy), 32'd1);
            next();
        end
        wr_valid = 1'b1;
        wr_data = 8'hA5;
        @(negedge clk);
        expect_wr(0);
        model[0] = 8'hA5;
        next();
        wr_valid = 1'b0;
        @(negedge clk);
        expect_rd(0, 1'b1);
        next();
        @(negedge clk);
        check("t2_caught_up", 32'(rd_grant), 32'd0);
        next();

        // T5: two more writes, then reset with a read in flight
        rd_req = 1'b0;
        wr_valid = 1'b1;
        for (int i = 1; i < 3; i++) begin
            wr_data = 8'(i);
            @(negedge clk);
            expect_wr(i);
            model[i] = wr_data;
            next();
        end
        wr_valid = 1'b0;
        rd_req = 1'b1;
        @(negedge clk);
        expect_rd(1, 1'b0);
        next();
        #1;
        reset_n = 1'b0;
        wr_valid = 1'b1;
        #1;
        check("t5_rd_valid", 32'(rd_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        expect_idle_bus();
        next();
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            expect_idle_bus();
            check("t5_idle", 32'(busy), 32'd0);
            next();
        end

        // T3 contention: W,R alternating, write first
        wr_valid = 1'b1;
        rd_req = 1'b1;
        wr_data = 8'h10;
        do_start();
        for (int k = 0; k < 16; k++) begin
            wr_data = 8'(8'h10 + k / 2);
            @(negedge clk);
            if (k % 2 == 0) begin
                expect_wr(k / 2);
                model[k/2] = wr_data;
            end else begin
                expect_rd(k / 2, 1'b1);
            end
            next();
        end
        @(negedge clk);
        check("t3_done", 32'(frame_done), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        expect_idle_bus();
        next();
        check("t3_done_count", 32'(n_done), 32'd2);

        // T4b start in DONE: new frame writes from addr 0
        rd_req = 1'b0;
        wr_data = 8'h55;
        do_start();
        @(negedge clk);
        expect_wr(0);
        next();
        @(negedge clk);
        expect_wr(1);
        next();
        wr_valid = 1'b0;
        next();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("done_total", 32'(n_done), 32'd2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
